// File: rtl/xadc_drp_scheduler.sv
// XADC DRP access scheduler: arbitrates end-of-conversion channel scans against
// host DRP accesses, enforces a DRDY timeout and keeps the latest result per slot.
module xadc_drp_scheduler #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   eoc_in,
   input  logic                   drdy_in,
   input  logic [15:0]            do_in,
   output logic                   den_out,
   output logic                   dwe_out,
   output logic [6:0]             daddr_out,
   output logic [15:0]            di_out,
   input  logic [7*NUM_CH-1:0]    ch_addr,
   input  logic [NUM_CH-1:0]      ch_enable,
   input  logic                   host_req,
   input  logic                   host_we,
   input  logic [6:0]             host_addr,
   input  logic [15:0]            host_wdata,
   output logic                   host_ack,
   output logic [15:0]            host_rdata,
   output logic                   host_err,
   output logic [16*NUM_CH-1:0]   sample_data,
   output logic [NUM_CH-1:0]      sample_valid,
   output logic                   sample_strobe,
   output logic [2:0]             sample_index,
   output logic                   timeout_err,
   output logic                   overrun_err,
   output logic                   busy
);

   localparam int unsigned CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

   typedef enum logic [2:0] {
      IDLE,
      SCAN_ISSUE,
      SCAN_WAIT,
      HOST_ISSUE,
      HOST_WAIT
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            ptr_q, ptr_d;
   logic [2:0]            slot_q, slot_d;
   logic                  scan_pending_q, scan_pending_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  host_we_q, host_we_d;
   logic                  den_q, den_d;
   logic                  dwe_q, dwe_d;
   logic [6:0]            daddr_q, daddr_d;
   logic [15:0]           di_q, di_d;
   logic                  host_ack_q, host_ack_d;
   logic [15:0]           host_rdata_q, host_rdata_d;
   logic                  host_err_q, host_err_d;
   logic [16*NUM_CH-1:0]  sample_data_q, sample_data_d;
   logic [NUM_CH-1:0]     sample_valid_q, sample_valid_d;
   logic                  strobe_q, strobe_d;
   logic [2:0]            index_q, index_d;
   logic                  timeout_q, timeout_d;
   logic                  overrun_q, overrun_d;

   logic                  sel_found;
   logic [2:0]            sel_slot;
   logic [6:0]            sel_addr;

   // Round-robin search: first enabled slot at or after ptr, wrapping.
   always_comb begin
      int unsigned idx;
      logic [NUM_CH-1:0]   en_sh;
      logic [7*NUM_CH-1:0] addr_sh;
      idx       = 0;
      en_sh     = '0;
      addr_sh   = '0;
      sel_found = 1'b0;
      sel_slot  = '0;
      sel_addr  = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         en_sh   = ch_enable >> idx;
         addr_sh = ch_addr >> (7 * idx);
         if (!sel_found && en_sh[0]) begin
            sel_found = 1'b1;
            sel_slot  = idx[2:0];
            sel_addr  = addr_sh[6:0];
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      slot_d         = slot_q;
      scan_pending_d = scan_pending_q | eoc_in;
      overrun_d      = overrun_q | (eoc_in & scan_pending_q);
      cnt_d          = cnt_q;
      host_we_d      = host_we_q;
      den_d          = 1'b0;
      dwe_d          = 1'b0;
      daddr_d        = daddr_q;
      di_d           = di_q;
      host_ack_d     = 1'b0;
      host_rdata_d   = host_rdata_q;
      host_err_d     = 1'b0;
      sample_data_d  = sample_data_q;
      sample_valid_d = sample_valid_q;
      strobe_d       = 1'b0;
      index_d        = index_q;
      timeout_d      = timeout_q;

      case (state_q)
         IDLE: begin
            // An eoc arriving in the decision cycle is served at once, so a
            // simultaneous host request waits behind it.
            if (scan_pending_q || eoc_in) begin
               scan_pending_d = 1'b0;
               if (sel_found) begin
                  state_d = SCAN_ISSUE;
                  den_d   = 1'b1;
                  daddr_d = sel_addr;
                  di_d    = '0;
                  slot_d  = sel_slot;
                  if (32'(sel_slot) + 1 >= NUM_CH) ptr_d = '0;
                  else                             ptr_d = sel_slot + 3'd1;
               end
            end else if (host_req && !host_ack_q) begin
               state_d   = HOST_ISSUE;
               den_d     = 1'b1;
               dwe_d     = host_we;
               daddr_d   = host_addr;
               di_d      = host_wdata;
               host_we_d = host_we;
            end
         end
         SCAN_ISSUE: begin
            state_d = SCAN_WAIT;
            cnt_d   = '0;
         end
         HOST_ISSUE: begin
            state_d = HOST_WAIT;
            cnt_d   = '0;
         end
         SCAN_WAIT, HOST_WAIT: begin
            if (drdy_in) begin
               state_d = IDLE;
               if (state_q == HOST_WAIT) begin
                  host_ack_d   = 1'b1;
                  host_rdata_d = host_we_q ? 16'h0000 : do_in;
               end else begin
                  strobe_d = 1'b1;
                  index_d  = slot_q;
                  for (int unsigned i = 0; i < NUM_CH; i++) begin
                     if (slot_q == 3'(i)) begin
                        sample_data_d[16*i +: 16] = do_in;
                        sample_valid_d[i]         = 1'b1;
                     end
                  end
               end
            // Abort on the cycle the count would reach TIMEOUT-1, so the
            // registered result lands TIMEOUT cycles after DEN.
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
               if (state_q == HOST_WAIT) begin
                  host_ack_d   = 1'b1;
                  host_err_d   = 1'b1;
                  host_rdata_d = 16'hFFFF;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         ptr_q          <= '0;
         slot_q         <= '0;
         scan_pending_q <= 1'b0;
         cnt_q          <= '0;
         host_we_q      <= 1'b0;
         den_q          <= 1'b0;
         dwe_q          <= 1'b0;
         daddr_q        <= '0;
         di_q           <= '0;
         host_ack_q     <= 1'b0;
         host_rdata_q   <= '0;
         host_err_q     <= 1'b0;
         sample_data_q  <= '0;
         sample_valid_q <= '0;
         strobe_q       <= 1'b0;
         index_q        <= '0;
         timeout_q      <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         slot_q         <= slot_d;
         scan_pending_q <= scan_pending_d;
         cnt_q          <= cnt_d;
         host_we_q      <= host_we_d;
         den_q          <= den_d;
         dwe_q          <= dwe_d;
         daddr_q        <= daddr_d;
         di_q           <= di_d;
         host_ack_q     <= host_ack_d;
         host_rdata_q   <= host_rdata_d;
         host_err_q     <= host_err_d;
         sample_data_q  <= sample_data_d;
         sample_valid_q <= sample_valid_d;
         strobe_q       <= strobe_d;
         index_q        <= index_d;
         timeout_q      <= timeout_d;
         overrun_q      <= overrun_d;
      end
   end

   assign den_out       = den_q;
   assign dwe_out       = dwe_q;
   assign daddr_out     = daddr_q;
   assign di_out        = di_q;
   assign host_ack      = host_ack_q;
   assign host_rdata    = host_rdata_q;
   assign host_err      = host_err_q;
   assign sample_data   = sample_data_q;
   assign sample_valid  = sample_valid_q;
   assign sample_strobe = strobe_q;
   assign sample_index  = index_q;
   assign timeout_err   = timeout_q;
   assign overrun_err   = overrun_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Scoreboard bench for xadc_drp_scheduler: planned DRP transactions are queued by
// the stimulus, and a monitor checks every DEN, strobe and host_ack against them.
module tb_xadc_drp_scheduler;

   localparam int NUM_CH  = 4;
   localparam int TIMEOUT = 64;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 eoc_in = 1'b0;
   logic                 drdy_in = 1'b0;
   logic [15:0]          do_in = '0;
   logic                 den_out, dwe_out;
   logic [6:0]           daddr_out;
   logic [15:0]          di_out;
   logic [7*NUM_CH-1:0]  ch_addr = '0;
   logic [NUM_CH-1:0]    ch_enable = '0;
   logic                 host_req = 1'b0;
   logic                 host_we = 1'b0;
   logic [6:0]           host_addr = '0;
   logic [15:0]          host_wdata = '0;
   logic                 host_ack, host_err;
   logic [15:0]          host_rdata;
   logic [16*NUM_CH-1:0] sample_data;
   logic [NUM_CH-1:0]    sample_valid;
   logic                 sample_strobe;
   logic [2:0]           sample_index;
   logic                 timeout_err, overrun_err, busy;

   xadc_drp_scheduler #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .eoc_in(eoc_in), .drdy_in(drdy_in), .do_in(do_in),
      .den_out(den_out), .dwe_out(dwe_out), .daddr_out(daddr_out), .di_out(di_out),
      .ch_addr(ch_addr), .ch_enable(ch_enable), .host_req(host_req), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
      .host_rdata(host_rdata), .host_err(host_err), .sample_data(sample_data),
      .sample_valid(sample_valid), .sample_strobe(sample_strobe),
      .sample_index(sample_index), .timeout_err(timeout_err),
      .overrun_err(overrun_err), .busy(busy)
   );

   // delay == 0 means the XADC never answers
   typedef struct {
      bit host; bit we; logic [6:0] addr; logic [15:0] di;
      int delay; logic [15:0] data; int slot;
   } plan_t;
   typedef struct {
      bit host; bit to; int slot; logic [15:0] data; bit err; int cycle;
   } comp_t;

   plan_t plan_q[$];
   comp_t comp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int resp_at = -100;
   int stray_at = -100;
   logic [15:0] resp_data = '0;
   logic [6:0]  last_addr = '0;
   int model_ptr = 0;
   logic [16*NUM_CH-1:0] exp_data = '0;
   logic [NUM_CH-1:0]    exp_valid = '0;
   bit exp_timeout = 0;
   bit exp_overrun = 0;

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // XADC responder: answers each DEN at the cycle the monitor scheduled.
   initial forever begin
      @(posedge clk);
      #1;
      drdy_in = (cyc == resp_at) || (cyc == stray_at);
      do_in   = (cyc == resp_at) ? resp_data : 16'($urandom);
   end

   // Monitor / scoreboard
   initial begin
      plan_t p;
      comp_t c;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (comp_q.size() != 0 && comp_q[0].cycle < cyc) begin
               check("cmp_missing", 64'(cyc), 64'(comp_q[0].cycle));
               void'(comp_q.pop_front());
            end
            if (comp_q.size() != 0 && !comp_q[0].host && comp_q[0].to && comp_q[0].cycle == cyc) begin
               check("scan_to_strobe", 64'(sample_strobe), 64'(0));
               check("scan_to_flag", 64'(timeout_err), 64'(1));
               check("scan_to_valid", 64'(sample_valid), 64'(exp_valid));
               void'(comp_q.pop_front());
            end
            if (den_out) begin
               if (plan_q.size() == 0) begin
                  check("den_unexpected", 64'(den_out), 64'(0));
               end else begin
                  p = plan_q.pop_front();
                  check("den_addr", 64'(daddr_out), 64'(p.addr));
                  check("den_we", 64'(dwe_out), 64'(p.we));
                  if (p.we) check("den_di", 64'(di_out), 64'(p.di));
                  last_addr = p.addr;
                  c.host = p.host;
                  c.to   = (p.delay == 0);
                  c.slot = p.slot;
                  c.err  = c.to;
                  if (c.to) begin
                     c.cycle = cyc + TIMEOUT;
                     c.data  = 16'hFFFF;
                  end else begin
                     resp_at   = cyc + p.delay;
                     resp_data = p.data;
                     c.cycle   = cyc + p.delay + 1;
                     c.data    = (p.host && p.we) ? 16'h0000 : p.data;
                  end
                  comp_q.push_back(c);
               end
            end else begin
               check("dwe_alone", 64'(dwe_out), 64'(0));
            end
            if (sample_strobe || host_ack) begin
               if (comp_q.size() == 0) begin
                  check("cmp_unexpected", 64'({sample_strobe, host_ack}), 64'(0));
               end else begin
                  c = comp_q.pop_front();
                  check("cmp_kind", 64'(host_ack), 64'(c.host));
                  check("cmp_cycle", 64'(cyc), 64'(c.cycle));
                  check("daddr_hold", 64'(daddr_out), 64'(last_addr));
                  if (c.host) begin
                     check("host_rdata", 64'(host_rdata), 64'(c.data));
                     check("host_err", 64'(host_err), 64'(c.err));
                  end else begin
                     exp_data[16*c.slot +: 16] = c.data;
                     exp_valid[c.slot] = 1'b1;
                     check("smp_index", 64'(sample_index), 64'(c.slot));
                     check("smp_data", 64'(sample_data), 64'(exp_data));
                     check("smp_valid", 64'(sample_valid), 64'(exp_valid));
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_eoc();
      eoc_in = 1'b1;
      tick();
      eoc_in = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || plan_q.size() != 0 || comp_q.size() != 0) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_queues", 64'(plan_q.size() + comp_q.size()), 64'(0));
      tick();
   endtask

   task automatic push_scan(input int delay, input logic [15:0] data);
      plan_t p;
      int s, cand;
      s = -1;
      for (int k = 0; k < NUM_CH; k++) begin
         cand = (model_ptr + k) % NUM_CH;
         if (s < 0 && ch_enable[cand]) s = cand;
      end
      if (s >= 0) begin
         model_ptr = (s + 1) % NUM_CH;
         p.host = 0; p.we = 0; p.addr = ch_addr[7*s +: 7]; p.di = '0;
         p.delay = delay; p.data = data; p.slot = s;
         plan_q.push_back(p);
         if (delay == 0) exp_timeout = 1;
      end
   endtask

   task automatic do_scan(input int delay, input logic [15:0] data, input bit mid_change);
      push_scan(delay, data);
      pulse_eoc();
      if (mid_change) begin
         tick();
         ch_addr   = {$urandom, $urandom};
         ch_enable = 4'($urandom);
      end
      wait_idle(TIMEOUT + 40);
   endtask

   task automatic host_op(input bit we, input logic [6:0] addr, input logic [15:0] wdata,
                          input int delay, input logic [15:0] rdata, input bit with_eoc);
      plan_t p;
      int n;
      if (with_eoc) push_scan(3, 16'($urandom));
      p.host = 1; p.we = we; p.addr = addr; p.di = wdata;
      p.delay = delay; p.data = rdata; p.slot = 0;
      plan_q.push_back(p);
      if (delay == 0) exp_timeout = 1;
      host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
      eoc_in = with_eoc;
      tick();
      eoc_in = 1'b0;
      n = 0;
      while (!host_ack && n < TIMEOUT + 60) begin
         @(negedge clk);
         n++;
      end
      check("host_ack_seen", 64'(host_ack), 64'(1));
      host_req = 1'b0;
      host_we = 1'($urandom); host_addr = 7'($urandom); host_wdata = 16'($urandom);
      wait_idle(TIMEOUT + 40);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, 64'({den_out, dwe_out, host_ack, host_err, sample_strobe, busy}), 64'(0));
      check({tag, "_drp"}, 64'({daddr_out, di_out}), 64'(0));
      check({tag, "_rd_idx"}, 64'({host_rdata, sample_index}), 64'(0));
      check({tag, "_sdata"}, 64'(sample_data), 64'(0));
      check({tag, "_valid_err"}, 64'({sample_valid, timeout_err, overrun_err}), 64'(0));
   endtask

   initial begin
      ch_addr = {$urandom, $urandom};
      repeat (3) tick();
      check_zero("reset");
      reset = 1'b0;
      tick();

      // Three scans over slots 0 and 2
      ch_enable = 4'b0101;
      do_scan(3, 16'h1230, 0);
      do_scan(3, 16'h4560, 0);
      do_scan(3, 16'h7890, 0);
      check("r39_valid", 64'(sample_valid), 64'(4'b0101));
      check("r39_slot0", 64'(sample_data[15:0]), 64'(16'h7890));
      check("r39_slot2", 64'(sample_data[47:32]), 64'(16'h4560));

      host_op(1'b1, 7'h41, 16'hA5A5, 3, 16'h5555, 0);
      host_op(1'b0, 7'h12, 16'h0000, 5, 16'hC3C3, 0);

      // eoc and host request together: scan goes first
      ch_enable = 4'b1010;
      host_op(1'b0, 7'h33, 16'h0000, 3, 16'h2468, 1);

      // Two eocs during a scan: one further scan, overrun flagged
      ch_enable = 4'b0011;
      push_scan(10, 16'h1111);
      push_scan(4, 16'h2222);
      pulse_eoc();
      tick(); tick();
      pulse_eoc();
      tick();
      pulse_eoc();
      exp_overrun = 1;
      wait_idle(100);
      repeat (20) tick();
      check("overrun_flag", 64'(overrun_err), 64'(exp_overrun));

      // Host read timeout
      host_op(1'b0, 7'h10, 16'h0000, 0, 16'h0000, 0);
      check("host_to_flag", 64'(timeout_err), 64'(1));

      // Scan timeout with a stray drdy during the issue cycle
      ch_enable = 4'b0100;
      stray_at = cyc + 1;
      do_scan(0, 16'h0000, 0);

      // drdy while idle is ignored
      stray_at = cyc + 2;
      repeat (5) tick();
      check("stray_busy", 64'(busy), 64'(0));

      // all-disabled scan is discarded
      ch_enable = '0;
      do_scan(3, 16'hDEAD, 0);

      for (int unsigned it = 0; it < 40; it++) begin
         if ($urandom_range(0, 9) < 5) begin
            ch_enable = 4'($urandom);
            do_scan($urandom_range(1, 12), 16'($urandom), 1'($urandom));
         end else begin
            host_op(1'($urandom), 7'($urandom), 16'($urandom),
                    $urandom_range(1, 12), 16'($urandom), 0);
         end
      end
      check("flags_timeout", 64'(timeout_err), 64'(exp_timeout));
      check("flags_overrun", 64'(overrun_err), 64'(exp_overrun));

      // Reset while a scan waits for DRDY; the late DRDY must be ignored
      ch_enable = 4'b1000;
      push_scan(10, 16'hBEEF);
      pulse_eoc();
      repeat (4) tick();
      check("pre_reset_busy", 64'(busy), 64'(1));
      reset = 1'b1;
      plan_q.delete();
      comp_q.delete();
      tick();
      check_zero("mid_reset");
      reset = 1'b0;
      model_ptr = 0; exp_data = '0; exp_valid = '0; exp_timeout = 0; exp_overrun = 0;
      repeat (12) tick();
      check_zero("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xadc_drp_scheduler.md
XADC_DRP_SCHEDULER -- requirements
Module: xadc_drp_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of scanned XADC channel slots (1..8).
REQ-002 Parameter TIMEOUT, default 64, max cycles waited for DRDY after DEN (>=2).
REQ-003 clk  in  1  system clock, also the XADC DCLK; all logic is rising-edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 eoc_in  in  1  XADC end-of-conversion pulse.
REQ-006 drdy_in  in  1  XADC DRP data-ready pulse.
REQ-007 do_in  in  16  XADC DRP read data.
REQ-008 den_out  out  1  DRP enable, single-cycle pulse.
REQ-009 dwe_out  out  1  DRP write enable, high only together with den_out on host writes.
REQ-010 daddr_out  out  7  DRP address, held stable from the DEN cycle until the transaction completes.
REQ-011 di_out  out  16  DRP write data, held with daddr_out.
REQ-012 ch_addr  in  7*NUM_CH  DRP address of slot i at bits [7i+6:7i].
REQ-013 ch_enable  in  NUM_CH  slot i is scanned when bit i = 1.
REQ-014 host_req  in  1  host DRP access request, held until host_ack.
REQ-015 host_we, host_addr[6:0], host_wdata[15:0]  in  host access control, sampled on the grant cycle.
REQ-016 host_ack  out  1  one-cycle completion pulse; host_rdata[15:0] and host_err valid in the same cycle.
REQ-017 sample_data  out  16*NUM_CH  last result of slot i at bits [16i+15:16i].
REQ-018 sample_valid  out  NUM_CH  slot i has been written at least once since reset.
REQ-019 sample_strobe  out  1  one-cycle pulse when a scan result is stored; sample_index[2:0] names the slot.
REQ-020 timeout_err, overrun_err  out  1 each  sticky error flags, cleared only by reset.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states: IDLE, SCAN_ISSUE, SCAN_WAIT, HOST_ISSUE, HOST_WAIT.
REQ-023 Any eoc_in pulse sets scan_pending; scan_pending clears when SCAN_ISSUE is entered.
REQ-024 An eoc_in pulse while scan_pending is already set sets overrun_err; no second scan is queued.
REQ-025 In IDLE, scan_pending has priority over host_req; when both are absent, remain in IDLE.
REQ-026 Scan slot selection: round-robin from ptr, picking the first enabled slot at or after ptr with wrap; ptr becomes the selected slot + 1 mod NUM_CH.
REQ-027 If ch_enable is all zero, a pending scan is discarded: return to IDLE, no DEN pulse, ptr unchanged.
REQ-028 SCAN_ISSUE and HOST_ISSUE last one cycle with den_out=1 and move to the corresponding WAIT state.
REQ-029 In either WAIT state, drdy_in=1 completes the transaction and the FSM returns to IDLE on the next cycle.
REQ-030 Scan completion: the cycle after drdy_in, sample_data[slot] <= do_in, sample_valid[slot] <= 1, and sample_strobe pulses with sample_index = slot.
REQ-031 Host completion: the cycle after drdy_in, host_ack=1, host_rdata = do_in (reads) or 16'h0000 (writes), and host_err=0.
REQ-032 Latency: DEN is asserted 1 cycle after the IDLE decision; result is registered 1 cycle after DRDY.
REQ-033 A WAIT-state counter starts at 0 on entry; if it reaches TIMEOUT-1 without drdy_in, the FSM returns to IDLE and sets timeout_err.
REQ-034 On a host timeout, host_ack pulses with host_err=1 and host_rdata=16'hFFFF; on a scan timeout, the slot is not updated and there is no strobe.
REQ-035 drdy_in in IDLE or an ISSUE state is ignored; eoc_in is still latched in every state.
REQ-036 ch_addr and ch_enable are sampled only at slot selection; changes mid-transaction have no effect on it.

Reset
REQ-037 While reset=1: FSM=IDLE, ptr=0, scan_pending=0, all outputs 0 including sample_data, sample_valid, and the error flags.
REQ-038 Reset asserted mid-transaction abandons it: no host_ack and no strobe; a late drdy_in after reset is ignored.

Verification
REQ-039 ch_enable=4'b0101, three eoc pulses, drdy 3 cycles after each DEN, do_in=16'h1230/4560/7890 -> reads slots 0,2,0; sample_data[0]=7890, [2]=4560; sample_valid=0101.
REQ-040 eoc_in and host_req rise in the same IDLE cycle -> scan DEN first; host DEN issued after the scan completes; host_ack follows its drdy by 1 cycle.
REQ-041 Host write addr 7'h41, data 16'hA5A5 -> one cycle with den_out=1, dwe_out=1, daddr_out=41, di_out=A5A5; host_ack with host_rdata=0000.
REQ-042 Host read with no drdy_in and TIMEOUT=64 -> host_ack with host_err=1 and rdata FFFF exactly 64 cycles after DEN; timeout_err stays 1.
REQ-043 Two eoc pulses while in SCAN_WAIT -> overrun_err=1; exactly one further scan is performed.
REQ-044 Reset pulse in SCAN_WAIT, then drdy_in -> no strobe, all outputs 0, FSM in IDLE.
